// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
//   Shared AHB-Lite types for the frame-buffer responder.
//   htrans_t       : bus transfer type encoding
//   HRESP_OKAY/ERR : single-bit response codes
//   slave_state_t  : responder FSM states
// ---------------------------------------------------------------------------
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DATA = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } slave_state_t;

endpackage

// File: rtl/ahb_sram_array.sv
// ---------------------------------------------------------------------------
// ahb_sram_array
//   Synchronous 1R1W word array, DEPTH x 32, registered read, no reset.
//   A read and a write to the same word on the same edge return the old
//   word; the caller is responsible for any forwarding.
// Ports
//   clk      in   clock, rising edge
//   wr_en    in   write strobe
//   wr_addr  in   write word index
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data updates only when set
//   rd_addr  in   read word index
//   rd_data  out  registered read data
// ---------------------------------------------------------------------------
module ahb_sram_array #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data
);

   logic [31:0] mem_r [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end else begin
         mem_r[wr_addr] <= mem_r[wr_addr];
      end
   end

   // Registered read port, holds its value between reads
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem_r[rd_addr];
      end else begin
         rd_data <= rd_data;
      end
   end

endmodule

// File: rtl/ahb_frame_slave.sv
// ---------------------------------------------------------------------------
// ahb_frame_slave
//   AHB-Lite responder in front of a word-addressed frame/line buffer.
//   Single transfers, programmable wait states on OKAY data phases,
//   two-cycle ERROR on bad addresses, back-to-back pipelined accepts.
// Parameters
//   DEPTH        words in the buffer (power of 2)
//   BASE_ADDR    byte address of word 0 (word aligned)
//   WAIT_STATES  hready-low cycles per OKAY data phase (0..7)
// Ports
//   clk     in   clock, rising edge
//   n_rst   in   asynchronous active-low reset
//   hsel    in   slave select
//   htrans  in   transfer type
//   hwrite  in   1 = write (address phase)
//   haddr   in   byte address (address phase)
//   hwdata  in   write data (data phase)
//   hrdata  out  read data
//   hready  out  transfer done / bus ready (also the bus hready-in)
//   hresp   out  0 OKAY, 1 ERROR
// ---------------------------------------------------------------------------
module ahb_frame_slave
   import ahb_pkg::*;
#(
   parameter int unsigned DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        hsel,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [31:0] haddr,
   input  logic [31:0] hwdata,
   output logic [31:0] hrdata,
   output logic        hready,
   output logic        hresp
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam bit          HAS_WAIT = (WAIT_STATES > 0);
   // Last counter value of the WAIT state; unused when there are no waits
   localparam logic [2:0]  WS_LAST  = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

   slave_state_t  state_r;
   slave_state_t  next_state_s;
   htrans_t       trans_s;

   logic          hready_s;
   logic          hresp_s;
   logic          accept_s;
   logic          addr_ok_s;
   logic [32:0]   diff_s;
   logic [AW-1:0] haddr_idx_s;

   logic [AW-1:0] idx_lat_r;
   logic          wr_lat_r;
   logic [2:0]    wait_cnt_r;
   logic          wait_done_s;

   logic          wr_en_s;
   logic          rd_load_s;
   logic [AW-1:0] rd_addr_s;
   logic          bypass_s;

   logic          rd_valid_r;
   logic          byp_r;
   logic [31:0]   byp_data_r;
   logic [31:0]   sram_q_s;

   // ---------------------------------------------------------------------
   // Address decode. The subtraction is one bit wider so that bit 32 is the
   // borrow, i.e. haddr below BASE_ADDR. Because BASE_ADDR is word aligned,
   // the low two offset bits equal the low two address bits.
   // ---------------------------------------------------------------------
   assign trans_s     = htrans_t'(htrans);
   assign diff_s      = {1'b0, haddr} - {1'b0, BASE_ADDR};
   assign haddr_idx_s = diff_s[AW+1:2];
   assign addr_ok_s   = (diff_s[1:0] == 2'b00)
                      && (diff_s[32] == 1'b0)
                      && (diff_s[31:AW+2] == '0);

   // A new address phase is taken only in the hready-high states
   assign accept_s    = hsel && hready_s
                      && ((trans_s == HTRANS_NONSEQ) || (trans_s == HTRANS_SEQ));

   assign wait_done_s = (wait_cnt_r == WS_LAST);

   // FSM state register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE, ST_DATA, ST_ERR2: begin
            if (accept_s) begin
               if (!addr_ok_s) begin
                  next_state_s = ST_ERR1;
               end else if (HAS_WAIT) begin
                  next_state_s = ST_WAIT;
               end else begin
                  next_state_s = ST_DATA;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (wait_done_s) begin
               next_state_s = ST_DATA;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_ERR1: next_state_s = ST_ERR2;
         default: next_state_s = ST_IDLE;
      endcase
   end

   // FSM outputs, decoded from the state register only
   always_comb begin
      hready_s = 1'b1;
      hresp_s  = HRESP_OKAY;
      case (state_r)
         ST_IDLE: begin hready_s = 1'b1; hresp_s = HRESP_OKAY;  end
         ST_WAIT: begin hready_s = 1'b0; hresp_s = HRESP_OKAY;  end
         ST_DATA: begin hready_s = 1'b1; hresp_s = HRESP_OKAY;  end
         ST_ERR1: begin hready_s = 1'b0; hresp_s = HRESP_ERROR; end
         ST_ERR2: begin hready_s = 1'b1; hresp_s = HRESP_ERROR; end
         default: begin hready_s = 1'b1; hresp_s = HRESP_OKAY;  end
      endcase
   end

   assign hready = hready_s;
   assign hresp  = hresp_s;

   // Address-phase latch: word index and direction of the accepted transfer
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         idx_lat_r <= '0;
         wr_lat_r  <= 1'b0;
      end else if (accept_s) begin
         idx_lat_r <= haddr_idx_s;
         wr_lat_r  <= hwrite;
      end else begin
         idx_lat_r <= idx_lat_r;
         wr_lat_r  <= wr_lat_r;
      end
   end

   // Wait-state counter: cleared on accept, counts up to WS_LAST, cleared on exit
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wait_cnt_r <= 3'd0;
      end else if (accept_s) begin
         wait_cnt_r <= 3'd0;
      end else if ((state_r == ST_WAIT) && !wait_done_s) begin
         wait_cnt_r <= wait_cnt_r + 3'd1;
      end else if (state_r == ST_WAIT) begin
         wait_cnt_r <= 3'd0;
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   // ---------------------------------------------------------------------
   // Memory control. The write of a DATA phase lands on the edge that ends
   // it. A read loads on the edge that enters DATA: from WAIT it uses the
   // latched index; with no wait states it is the accept edge itself, so the
   // live address is used. Only the zero-wait pipelined case can see a write
   // and a read load on the same edge, hence the bypass compare.
   // ---------------------------------------------------------------------
   assign wr_en_s = (state_r == ST_DATA) && wr_lat_r;

   // Read-load strobe and read index selection
   always_comb begin
      rd_load_s = 1'b0;
      rd_addr_s = idx_lat_r;
      if (state_r == ST_WAIT) begin
         rd_load_s = wait_done_s && !wr_lat_r;
         rd_addr_s = idx_lat_r;
      end else if (!HAS_WAIT && accept_s && addr_ok_s && !hwrite) begin
         rd_load_s = 1'b1;
         rd_addr_s = haddr_idx_s;
      end else begin
         rd_load_s = 1'b0;
         rd_addr_s = idx_lat_r;
      end
   end

   assign bypass_s = rd_load_s && wr_en_s && (rd_addr_s == idx_lat_r);

   ahb_sram_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_sram (
      .clk     (clk),
      .wr_en   (wr_en_s),
      .wr_addr (idx_lat_r),
      .wr_data (hwdata),
      .rd_en   (rd_load_s),
      .rd_addr (rd_addr_s),
      .rd_data (sram_q_s)
   );

   // Read-data bookkeeping: has any read loaded since reset, and was it forwarded
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rd_valid_r <= 1'b0;
         byp_r      <= 1'b0;
         byp_data_r <= 32'h0000_0000;
      end else if (rd_load_s) begin
         rd_valid_r <= 1'b1;
         byp_r      <= bypass_s;
         byp_data_r <= bypass_s ? hwdata : byp_data_r;
      end else begin
         rd_valid_r <= rd_valid_r;
         byp_r      <= byp_r;
         byp_data_r <= byp_data_r;
      end
   end

   // The array has no reset, so hrdata reads zero until the first read lands
   assign hrdata = !rd_valid_r ? 32'h0000_0000
                 : (byp_r ? byp_data_r : sram_q_s);

endmodule

// File: tb/tb_ahb_frame_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_frame_slave
//   Directed bench with two responders sharing the bus signals: one with a
//   single wait state, one with none. Each has its own hsel.
// ---------------------------------------------------------------------------
module tb_ahb_frame_slave;
   import ahb_pkg::*;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        hsel1;
   logic        hsel0;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic [31:0] hrdata1;
   logic [31:0] hrdata0;
   logic        hready1;
   logic        hready0;
   logic        hresp1;
   logic        hresp0;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ahb_frame_slave #(
      .DEPTH       (1024),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_STATES (1)
   ) u_dut_ws1 (
      .clk    (clk),
      .n_rst  (n_rst),
      .hsel   (hsel1),
      .htrans (htrans),
      .hwrite (hwrite),
      .haddr  (haddr),
      .hwdata (hwdata),
      .hrdata (hrdata1),
      .hready (hready1),
      .hresp  (hresp1)
   );

   ahb_frame_slave #(
      .DEPTH       (1024),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_STATES (0)
   ) u_dut_ws0 (
      .clk    (clk),
      .n_rst  (n_rst),
      .hsel   (hsel0),
      .htrans (htrans),
      .hwrite (hwrite),
      .haddr  (haddr),
      .hwdata (hwdata),
      .hrdata (hrdata0),
      .hready (hready0),
      .hresp  (hresp0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      hsel1  = 1'b0;
      hsel0  = 1'b0;
      htrans = HTRANS_IDLE;
      hwrite = 1'b0;
      haddr  = 32'h0000_0000;
   endtask

   task automatic addr_phase(input logic to_ws1, input logic wr, input logic [31:0] a);
      hsel1  = to_ws1;
      hsel0  = !to_ws1;
      htrans = HTRANS_NONSEQ;
      hwrite = wr;
      haddr  = a;
   endtask

   // Complete non-pipelined transfer on the one-wait-state responder
   task automatic xfer1(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] d);
      addr_phase(1'b1, wr, a);
      tick();
      check({tag, "_wait_hready"}, 32'(hready1), 32'h0000_0000);
      bus_idle();
      hwdata = d;
      tick();
      check({tag, "_data_hready"}, 32'(hready1), 32'h0000_0001);
      check({tag, "_data_hresp"}, 32'(hresp1), 32'h0000_0000);
      if (!wr) begin
         check({tag, "_hrdata"}, hrdata1, d);
      end
      tick();
   endtask

   // Complete non-pipelined transfer on the zero-wait-state responder
   task automatic xfer0(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] d);
      addr_phase(1'b0, wr, a);
      tick();
      check({tag, "_data_hready"}, 32'(hready0), 32'h0000_0001);
      bus_idle();
      hwdata = d;
      if (!wr) begin
         check({tag, "_hrdata"}, hrdata0, d);
      end
      tick();
   endtask

   initial begin
      // 1: reset values, held across idle cycles
      n_rst  = 1'b0;
      hwdata = 32'h0000_0000;
      bus_idle();
      #2;
      check("rst_hready1", 32'(hready1), 32'h0000_0001);
      check("rst_hresp1",  32'(hresp1),  32'h0000_0000);
      check("rst_hrdata1", hrdata1,      32'h0000_0000);
      check("rst_hready0", 32'(hready0), 32'h0000_0001);
      check("rst_hresp0",  32'(hresp0),  32'h0000_0000);
      check("rst_hrdata0", hrdata0,      32'h0000_0000);
      repeat (3) tick();
      check("rst_hold_hready1", 32'(hready1), 32'h0000_0001);
      check("rst_hold_hrdata1", hrdata1,      32'h0000_0000);
      n_rst = 1'b1;
      tick();
      check("post_rst_hready1", 32'(hready1), 32'h0000_0001);
      check("post_rst_hresp1",  32'(hresp1),  32'h0000_0000);

      // 2: one wait state, write then read back
      xfer1("t2_wr", 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
      xfer1("t2_rd", 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
      check("t2_hrdata_held", hrdata1, 32'hDEAD_BEEF);

      // 3: out-of-range and misaligned addresses give a two-cycle ERROR
      xfer1("t3_seed", 1'b1, 32'h0000_0000, 32'h0000_5A5A);
      check("t3_hrdata_not_by_write", hrdata1, 32'hDEAD_BEEF);
      addr_phase(1'b1, 1'b0, 32'h0000_1000);
      tick();
      check("t3a_err1_hready", 32'(hready1), 32'h0000_0000);
      check("t3a_err1_hresp",  32'(hresp1),  32'h0000_0001);
      addr_phase(1'b1, 1'b1, 32'h0000_0102);
      hwdata = 32'hBAD0_BAD0;
      tick();
      check("t3a_err2_hready", 32'(hready1), 32'h0000_0001);
      check("t3a_err2_hresp",  32'(hresp1),  32'h0000_0001);
      tick();
      check("t3b_err1_hready", 32'(hready1), 32'h0000_0000);
      check("t3b_err1_hresp",  32'(hresp1),  32'h0000_0001);
      bus_idle();
      tick();
      check("t3b_err2_hready", 32'(hready1), 32'h0000_0001);
      check("t3b_err2_hresp",  32'(hresp1),  32'h0000_0001);
      tick();
      check("t3_idle_hready", 32'(hready1), 32'h0000_0001);
      check("t3_idle_hresp",  32'(hresp1),  32'h0000_0000);
      check("t3_hrdata_not_by_err", hrdata1, 32'hDEAD_BEEF);
      xfer1("t3_rd0", 1'b0, 32'h0000_0000, 32'h0000_5A5A);

      // 4: zero wait states, write immediately followed by read of same word
      xfer0("t4_seed", 1'b1, 32'h0000_0040, 32'h0BAD_0BAD);
      addr_phase(1'b0, 1'b1, 32'h0000_0040);
      tick();
      check("t4_wr_hready", 32'(hready0), 32'h0000_0001);
      hwdata = 32'h1234_5678;
      addr_phase(1'b0, 1'b0, 32'h0000_0040);
      tick();
      check("t4_rd_hready", 32'(hready0), 32'h0000_0001);
      check("t4_rd_hresp",  32'(hresp0),  32'h0000_0000);
      check("t4_bypass",    hrdata0,      32'h1234_5678);
      bus_idle();
      tick();
      check("t4_held", hrdata0, 32'h1234_5678);
      xfer0("t4_rd_mem", 1'b0, 32'h0000_0040, 32'h1234_5678);

      // 5: IDLE and BUSY transfers are ignored
      xfer1("t5_seed", 1'b1, 32'h0000_0008, 32'h1111_2222);
      hsel1  = 1'b1;
      hwrite = 1'b1;
      haddr  = 32'h0000_0008;
      htrans = HTRANS_IDLE;
      hwdata = 32'hFFFF_FFFF;
      tick();
      check("t5_idle_hready", 32'(hready1), 32'h0000_0001);
      check("t5_idle_hresp",  32'(hresp1),  32'h0000_0000);
      htrans = HTRANS_BUSY;
      tick();
      check("t5_busy_hready", 32'(hready1), 32'h0000_0001);
      tick();
      check("t5_busy2_hready", 32'(hready1), 32'h0000_0001);
      bus_idle();
      xfer1("t5_rd", 1'b0, 32'h0000_0008, 32'h1111_2222);

      // 6: reset during the wait state aborts the pending write
      xfer1("t6_seed", 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
      addr_phase(1'b1, 1'b1, 32'h0000_0020);
      tick();
      check("t6_wait_hready", 32'(hready1), 32'h0000_0000);
      bus_idle();
      hwdata = 32'hAAAA_AAAA;
      #2;
      n_rst = 1'b0;
      #1;
      check("t6_rst_hready", 32'(hready1), 32'h0000_0001);
      check("t6_rst_hresp",  32'(hresp1),  32'h0000_0000);
      check("t6_rst_hrdata", hrdata1,      32'h0000_0000);
      tick();
      n_rst = 1'b1;
      tick();
      xfer1("t6_rd", 1'b0, 32'h0000_0020, 32'hCAFE_F00D);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
